// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_GNT  = 2'd1,
    WAIT_RESP = 2'd2
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] WORD_INC         = 32'd4;

  // One prefetch buffer entry: the PC it was fetched from and the word itself.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Fetch addresses are always word addresses.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer between the memory interface and the decode stage.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module fetch_fifo
  import fetch_stage_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output fetch_entry_t               head
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          do_push;
  logic          do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign count   = wr_ptr_q - rd_ptr_q;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr_q[AW-1:0]];

  // Next pointer values; a flush empties the buffer and overrides push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are only observed through head when not empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: single-outstanding request FSM, fetch PC and
// redirect handling, feeding a small prefetch buffer toward decode.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        id_stall,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);

  localparam int              CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]   DEPTH_CNT = CW'(FIFO_DEPTH);

  fetch_state_e  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic          drop_q, drop_d;
  logic          req_q, req_d;
  logic [31:0]   addr_q, addr_d;

  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  fetch_entry_t  fifo_head;
  fetch_entry_t  push_entry;
  logic          slot_free;

  // A pop frees a slot this cycle, so it counts as room for a new request.
  assign fifo_pop   = !fifo_empty && !id_stall && !redirect;
  assign slot_free  = (fifo_count < DEPTH_CNT) || fifo_pop;
  assign fifo_push  = (state_q == WAIT_RESP) && imem_rvalid && !drop_q && !redirect
                      && (!fifo_full || fifo_pop);
  assign push_entry = {addr_q, imem_rdata};

  // Next-state logic for the request FSM, fetch PC and drop flag.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    req_d   = req_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (redirect) begin
          pc_d = word_align(redirect_pc);
        end else if (slot_free) begin
          state_d = WAIT_GNT;
          req_d   = 1'b1;
          addr_d  = pc_q;
        end
      end
      WAIT_GNT: begin
        if (redirect) begin
          pc_d   = word_align(redirect_pc);
          drop_d = 1'b1;
        end
        if (imem_gnt) begin
          state_d = WAIT_RESP;
          req_d   = 1'b0;
          if (!redirect && !drop_q) pc_d = pc_q + WORD_INC;
        end
      end
      WAIT_RESP: begin
        if (redirect) begin
          pc_d   = word_align(redirect_pc);
          drop_d = 1'b1;
        end
        if (imem_rvalid) begin
          state_d = IDLE;
          drop_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // FSM state and registered memory-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .flush     (redirect),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign if_valid  = !fifo_empty;
  assign if_pc     = fifo_head.pc;
  assign if_instr  = fifo_head.instr;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage with a scripted memory.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_stall;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] I0  = 32'h1111_0000;
  localparam logic [31:0] I1  = 32'h2222_0004;
  localparam logic [31:0] I2  = 32'h3333_0008;
  localparam logic [31:0] I3  = 32'h4444_0100;
  localparam logic [31:0] I4  = 32'h5555_0200;
  localparam logic [31:0] I5  = 32'h6666_0300;
  localparam logic [31:0] I6  = 32'h7777_FFFC;
  localparam logic [31:0] BAD = 32'hBAD0_BAD0;

  typedef struct {
    logic        rst;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        redir;
    logic [31:0] rpc;
    logic        stall;
    logic        ereq;
    logic [31:0] eaddr;
    logic        evalid;
    logic [31:0] epc;
    logic [31:0] einstr;
  } vec_t;

  vec_t vecs[$];

  fetch_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .id_stall    (id_stall),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .if_instr    (if_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic addV(input logic rst, input logic gnt, input logic rv, input logic [31:0] rd,
                      input logic rdr, input logic [31:0] rpc, input logic st,
                      input logic ereq, input logic [31:0] ea, input logic ev,
                      input logic [31:0] ep, input logic [31:0] ei);
    vec_t v;
    v.rst = rst; v.gnt = gnt; v.rvalid = rv; v.rdata = rd; v.redir = rdr; v.rpc = rpc;
    v.stall = st; v.ereq = ereq; v.eaddr = ea; v.evalid = ev; v.epc = ep; v.einstr = ei;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic gnt, input logic rv, input logic [31:0] rd,
                               input logic rdr, input logic [31:0] rpc, input logic st);
    imem_gnt    = gnt;
    imem_rvalid = rv;
    imem_rdata  = rd;
    redirect    = rdr;
    redirect_pc = rpc;
    id_stall    = st;
  endtask

  task automatic checkOutput(input string name, input logic ereq, input logic [31:0] ea,
                             input logic ev, input logic [31:0] ep, input logic [31:0] ei);
    checks++;
    if (imem_req !== ereq || imem_addr !== ea || if_valid !== ev ||
        if_pc !== ep || if_instr !== ei) begin
      errors++;
      $display("[TB] FAIL %s: got req=%0b addr=%h valid=%0b pc=%h instr=%h, expected req=%0b addr=%h valid=%0b pc=%h instr=%h",
               name, imem_req, imem_addr, if_valid, if_pc, if_instr, ereq, ea, ev, ep, ei);
    end
  endtask

  // Reset for two cycles and release on a falling edge.
  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("held_reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Scenario: gnt same cycle as req, rvalid next cycle, no stall.
    addV(1, 1,0,0,   0,0,0,  1,32'h0,0,0,0);
    addV(0, 0,1,I0,  0,0,0,  0,32'h0,0,0,0);
    addV(0, 0,0,0,   0,0,0,  0,32'h0,1,32'h0,I0);
    addV(0, 1,0,0,   0,0,0,  1,32'h4,0,0,0);
    addV(0, 0,1,I1,  0,0,0,  0,32'h4,0,0,0);
    addV(0, 0,0,0,   0,0,0,  0,32'h4,1,32'h4,I1);
    addV(0, 1,0,0,   0,0,0,  1,32'h8,0,0,0);
    addV(0, 0,1,I2,  0,0,0,  0,32'h8,0,0,0);
    addV(0, 0,0,0,   0,0,0,  0,32'h8,1,32'h8,I2);
    addV(0, 0,0,0,   0,0,0,  1,32'hC,0,0,0);

    // Scenario: stall for 5 cycles fills the buffer and stops requests.
    addV(1, 1,0,0,   0,0,0,  1,32'h0,0,0,0);
    addV(0, 0,1,I0,  0,0,0,  0,32'h0,0,0,0);
    addV(0, 0,0,0,   0,0,1,  0,32'h0,1,32'h0,I0);
    addV(0, 1,0,0,   0,0,1,  1,32'h4,1,32'h0,I0);
    addV(0, 0,1,I1,  0,0,1,  0,32'h4,1,32'h0,I0);
    addV(0, 0,0,0,   0,0,1,  0,32'h4,1,32'h0,I0);
    addV(0, 0,0,0,   0,0,1,  0,32'h4,1,32'h0,I0);
    addV(0, 0,0,0,   0,0,0,  0,32'h4,1,32'h0,I0);
    addV(0, 1,0,0,   0,0,0,  1,32'h8,1,32'h4,I1);
    addV(0, 0,1,I2,  0,0,0,  0,32'h8,0,0,0);
    addV(0, 0,0,0,   0,0,0,  0,32'h8,1,32'h8,I2);
    addV(0, 0,0,0,   0,0,0,  1,32'hC,0,0,0);

    // Scenario: redirect to an unaligned target while waiting for a response.
    addV(1, 1,0,0,   0,0,0,            1,32'h0,0,0,0);
    addV(0, 0,0,0,   1,32'h0000_0103,0, 0,32'h0,0,0,0);
    addV(0, 0,1,BAD, 0,0,0,            0,32'h0,0,0,0);
    addV(0, 0,0,0,   0,0,0,            0,32'h0,0,0,0);
    addV(0, 1,0,0,   0,0,0,            1,32'h100,0,0,0);
    addV(0, 0,1,I3,  0,0,0,            0,32'h100,0,0,0);
    addV(0, 0,0,0,   0,0,0,            0,32'h100,1,32'h100,I3);
    addV(0, 0,0,0,   0,0,0,            1,32'h104,0,0,0);

    // Scenario: redirect together with rvalid while decode is stalled.
    addV(1, 1,0,0,   0,0,1,            1,32'h0,0,0,0);
    addV(0, 0,1,I0,  0,0,1,            0,32'h0,0,0,0);
    addV(0, 0,0,0,   0,0,1,            0,32'h0,1,32'h0,I0);
    addV(0, 1,0,0,   0,0,1,            1,32'h4,1,32'h0,I0);
    addV(0, 0,1,BAD, 1,32'h200,1,      0,32'h4,1,32'h0,I0);
    addV(0, 0,0,0,   0,0,0,            0,32'h4,0,0,0);
    addV(0, 1,0,0,   0,0,0,            1,32'h200,0,0,0);
    addV(0, 0,1,I4,  0,0,0,            0,32'h200,0,0,0);
    addV(0, 0,0,0,   0,0,0,            0,32'h200,1,32'h200,I4);

    // Scenario: grant withheld 3 cycles, redirect in the second; stray rvalid ignored.
    addV(1, 0,0,0,   0,0,0,            1,32'h0,0,0,0);
    addV(0, 0,0,0,   1,32'h300,0,      1,32'h0,0,0,0);
    addV(0, 0,1,BAD, 0,0,0,            1,32'h0,0,0,0);
    addV(0, 1,0,0,   0,0,0,            1,32'h0,0,0,0);
    addV(0, 0,1,BAD, 0,0,0,            0,32'h0,0,0,0);
    addV(0, 0,0,0,   0,0,0,            0,32'h0,0,0,0);
    addV(0, 1,0,0,   0,0,0,            1,32'h300,0,0,0);
    addV(0, 0,1,I5,  0,0,0,            0,32'h300,0,0,0);
    addV(0, 0,0,0,   0,0,0,            0,32'h300,1,32'h300,I5);

    // Scenario: back-to-back redirects (last wins) and PC wrap at the top.
    addV(1, 1,0,0,   1,32'h500,0,        1,32'h0,0,0,0);
    addV(0, 0,0,0,   1,32'hFFFF_FFFE,0,  0,32'h0,0,0,0);
    addV(0, 0,1,BAD, 0,0,0,              0,32'h0,0,0,0);
    addV(0, 0,0,0,   0,0,0,              0,32'h0,0,0,0);
    addV(0, 1,0,0,   0,0,0,              1,32'hFFFF_FFFC,0,0,0);
    addV(0, 0,1,I6,  0,0,0,              0,32'hFFFF_FFFC,0,0,0);
    addV(0, 0,0,0,   0,0,0,              0,32'hFFFF_FFFC,1,32'hFFFF_FFFC,I6);
    addV(0, 0,0,0,   0,0,0,              1,32'h0,0,0,0);

    @(negedge clk);
    checkOutput("reset_state", 0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) doReset();
      @(negedge clk);
      checkOutput($sformatf("vec%0d", i), vecs[i].ereq, vecs[i].eaddr, vecs[i].evalid,
                  vecs[i].epc, vecs[i].einstr);
      applyStimulus(vecs[i].gnt, vecs[i].rvalid, vecs[i].rdata, vecs[i].redir,
                    vecs[i].rpc, vecs[i].stall);
    end

    // Reset asserted mid-response wait, then a stale rvalid after release.
    doReset();
    @(negedge clk);
    checkOutput("rst_mid_req", 1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("rst_mid_wait", 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1 checkOutput("rst_async", 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("rst_hold", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_first_req", 1, 0, 0, 0, 0);
    applyStimulus(0, 1, BAD, 0, 0, 0);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("rst_stale_rvalid", 1, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput($sformatf("rst_after%0d", k), 1, 0, 0, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
